// File: rtl/tone_freq_mapper.sv
// tone_freq_mapper: maps theremin samples to note frequencies using a shared
// multi-cycle restoring divider (quotient pass, then modulo pass).
// Ports: clk, rst_n (async low); tone_valid/tone_ready/tone/mode sample in;
//        freq_valid/freq registered result out; busy while converting.
// Optional: define TONE_FREQ_GLIDE_EN to slew freq by GLIDE_STEP in modes 0/1.
module tone_freq_mapper #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 32,
    parameter int DIV        = 10,
    parameter int OFFSET     = 50,
    parameter int RANGE      = 232,
    parameter int BASE_FREQ  = 294,
    parameter int MUTE_FREQ  = 20000,
    parameter int NOTE_SHIFT = 4,
    parameter int GLIDE_STEP = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tone_valid,
    output logic             tone_ready,
    input  logic [IN_W-1:0]  tone,
    input  logic [1:0]       mode,
    output logic             freq_valid,
    output logic [OUT_W-1:0] freq,
    output logic             busy
);

    localparam int RW = IN_W + 1;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

`ifdef TONE_FREQ_GLIDE_EN
    localparam bit GLIDE = 1'b1;
`else
    localparam bit GLIDE = 1'b0;
`endif

    // Without glide the slew limit is all-ones, so freq lands on target.
    localparam logic [OUT_W-1:0] STEP_LIM = GLIDE ? OUT_W'(GLIDE_STEP) : '1;
    localparam logic [OUT_W-1:0] BASE     = OUT_W'(BASE_FREQ);
    localparam logic [OUT_W-1:0] MUTE     = OUT_W'(MUTE_FREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVQ,
        S_DIVM,
        S_MAP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [IN_W-1:0]   r_dvd;
    logic [RW-1:0]     r_rem;
    logic [IN_W-1:0]   r_d;
    logic [1:0]        r_mode;
    logic [OUT_W-1:0]  r_freq;
    logic              r_fv;

    logic              w_last;
    logic [RW-1:0]     w_dvs;
    logic [RW-1:0]     w_rem_sh;
    logic              w_ge;
    logic [RW-1:0]     w_rem_nx;
    logic [IN_W-1:0]   w_dvd_nx;
    logic [IN_W-1:0]   w_d;
    logic [IN_W-1:0]   w_dcl;
    logic [IN_W-1:0]   w_idx;
    logic [3:0]        w_ni;
    logic [OUT_W-1:0]  w_target;
    logic [OUT_W-1:0]  w_diff;
    logic [OUT_W-1:0]  w_freq_nx;

    function automatic logic [OUT_W-1:0] note_hz(input logic [3:0] i);
        case (i)
            4'd0:    note_hz = OUT_W'(294);
            4'd1:    note_hz = OUT_W'(330);
            4'd2:    note_hz = OUT_W'(349);
            4'd3:    note_hz = OUT_W'(392);
            4'd4:    note_hz = OUT_W'(440);
            4'd5:    note_hz = OUT_W'(494);
            4'd6:    note_hz = OUT_W'(524);
            4'd7:    note_hz = OUT_W'(588);
            4'd8:    note_hz = OUT_W'(660);
            4'd9:    note_hz = OUT_W'(698);
            4'd10:   note_hz = OUT_W'(784);
            4'd11:   note_hz = OUT_W'(880);
            4'd12:   note_hz = OUT_W'(988);
            4'd13:   note_hz = OUT_W'(1048);
            default: note_hz = OUT_W'(1176);
        endcase
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (tone_valid) w_next = S_DIVQ;
            S_DIVQ:  if (w_last) w_next = S_DIVM;
            S_DIVM:  if (w_last) w_next = S_MAP;
            S_MAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tone_ready = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
    end

    // ---------------- shared restoring divider step ----------------
    assign w_last   = (r_cnt == CW'(IN_W - 1));
    assign w_dvs    = (r_state == S_DIVM) ? RW'(RANGE) : RW'(DIV);
    assign w_rem_sh = {r_rem[IN_W-1:0], r_dvd[IN_W-1]};
    assign w_ge     = (w_rem_sh >= w_dvs);
    assign w_rem_nx = w_ge ? (w_rem_sh - w_dvs) : w_rem_sh;
    assign w_dvd_nx = {r_dvd[IN_W-2:0], w_ge};

    // On the last quotient step w_dvd_nx is the full quotient; saturate at 0.
    assign w_d = (w_dvd_nx >= IN_W'(OFFSET)) ? (w_dvd_nx - IN_W'(OFFSET))
                                             : '0;

    // ---------------- mapping ----------------
    assign w_dcl = (r_d > IN_W'(RANGE - 1)) ? IN_W'(RANGE - 1) : r_d;
    assign w_idx = w_dcl >> NOTE_SHIFT;
    assign w_ni  = (w_idx > IN_W'(14)) ? 4'd14 : w_idx[3:0];

    always_comb begin
        w_target = MUTE;
        case (r_mode)
            2'd0:    w_target = BASE + OUT_W'(r_rem);
            2'd1:    w_target = BASE + OUT_W'(w_dcl);
            2'd2:    w_target = note_hz(w_ni);
            default: w_target = MUTE;
        endcase
    end

    // Modes 0/1 slew toward target; snap and mute always jump.
    always_comb begin
        w_diff    = '0;
        w_freq_nx = w_target;
        if (!r_mode[1]) begin
            if (w_target > r_freq) begin
                w_diff    = w_target - r_freq;
                w_freq_nx = r_freq + ((w_diff > STEP_LIM) ? STEP_LIM : w_diff);
            end else begin
                w_diff    = r_freq - w_target;
                w_freq_nx = r_freq - ((w_diff > STEP_LIM) ? STEP_LIM : w_diff);
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_rem  <= '0;
            r_d    <= '0;
            r_mode <= '0;
            r_freq <= MUTE;
            r_fv   <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tone_valid) begin
                        r_dvd  <= tone;
                        r_rem  <= '0;
                        r_mode <= mode;
                        r_cnt  <= '0;
                    end
                end
                S_DIVQ: begin
                    if (w_last) begin
                        // Reload divider with d for the modulo pass.
                        r_dvd <= w_d;
                        r_d   <= w_d;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_dvd <= w_dvd_nx;
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIVM: begin
                    r_dvd <= w_dvd_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                S_MAP: begin
                    r_freq <= w_freq_nx;
                    r_fv   <= 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign freq       = r_freq;
    assign freq_valid = r_fv;

endmodule
